topmod_spi: RTL and testbench

- Single-channel SPI master, mode 0 (CPOL=0, CPHA=0), fixed 16-bit full-duplex frames, MSB first.
- A one-cycle `send` strobe starts a frame. The block transmits `data_in` on MOSI while capturing MISO.
- At frame end it presents the received word on `data_out` and pulses `done`.
- Sits between a register/bus wrapper (e.g. APB slave) and the external SPI pins. With a 10 MHz `clk` it produces a 625 kHz SCLK.

---
 rtl/topmod_spi_pkg.sv | 19 +
 rtl/topmod_spi_sclk_gen.sv | 42 ++++
 rtl/topmod_spi.sv | 106 ++++++++++
 tb/tb_topmod_spi.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/topmod_spi_pkg.sv
// Shared defaults, FSM state encoding and a sizing helper for the SPI master.
package topmod_spi_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int HALF_DIV_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } spi_state_e;

    // Bits needed to hold the value n (at least 1).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/topmod_spi_sclk_gen.sv
// SCLK divider: HALF_DIV cycles low, HALF_DIV cycles high, with one-cycle
// enables asserted in the cycle whose closing edge makes SCLK rise or fall.
module spi_sclk_gen
    import topmod_spi_pkg::*;
#(
    parameter int HALF_DIV = HALF_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int DIV_W = cnt_w(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_tick;

    assign w_tick = i_en && (r_div == DIV_MAX);

    // Dropping the enable parks the divider so every frame starts on a full low half.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    assign o_sclk = r_sclk;
    assign o_rise = w_tick && !r_sclk;
    assign o_fall = w_tick &&  r_sclk;

endmodule

// File: rtl/topmod_spi.sv
// Mode-0 SPI master: fixed DATA_W-bit full-duplex frames, MSB first, with an
// IDLE/LOAD/XFER/DONE sequencer around tx/rx shift registers.
module topmod_spi
    import topmod_spi_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HALF_DIV = HALF_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCLK,
    output logic              SS
);

    localparam int CNT_W = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_e r_state, w_next;

    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_data_out;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_done;
    logic              r_ss;

    logic w_sclk_en;
    logic w_sclk;
    logic w_rise;
    logic w_fall;
    logic w_last_fall;

    assign w_sclk_en   = (r_state == XFER);
    assign w_last_fall = w_fall && (r_bit_cnt == LAST_BIT);

    spi_sclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (w_sclk_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (send) w_next = LOAD;
            LOAD:    w_next = XFER;
            XFER:    if (w_last_fall) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // SS and done are registered from the next state so the pins never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_bit_cnt  <= '0;
            r_done     <= 1'b0;
            r_ss       <= 1'b1;
        end else begin
            r_ss   <= (w_next == IDLE);
            r_done <= (w_next == DONE);
            if (r_state == LOAD) begin
                r_tx      <= data_in;
                r_rx      <= '0;
                r_bit_cnt <= '0;
            end
            if (r_state == XFER) begin
                if (w_rise)
                    r_rx <= {r_rx[DATA_W-2:0], MISO};
                if (w_fall) begin
                    r_tx      <= {r_tx[DATA_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
            // rx is already complete here: the last rise was half a bit earlier.
            if (w_last_fall)
                r_data_out <= r_rx;
        end
    end

    assign MOSI     = (r_state == XFER) && r_tx[DATA_W-1];
    assign SCLK     = w_sclk;
    assign SS       = r_ss;
    assign done     = r_done;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_topmod_spi.sv
// Bench for topmod_spi: a frame-position model predicts every pin each cycle,
// plus literal word checks for the hand-worked frames.
module tb_topmod_spi;

    localparam int DW     = 16;
    localparam int HD     = 8;
    localparam int BITC   = 2 * HD;
    localparam int LAST_K = 1 + DW * BITC;   // last XFER cycle; LAST_K+1 is the done cycle

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          send = 1'b0;
    logic          MISO = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          done, MOSI, SCLK, SS;

    always #5 clk = ~clk;

    topmod_spi #(.DATA_W(DW), .HALF_DIV(HD)) dut (
        .clk      (clk),
        .rst      (rst),
        .send     (send),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done),
        .MISO     (MISO),
        .MOSI     (MOSI),
        .SCLK     (SCLK),
        .SS       (SS)
    );

    // Model: m_k is the cycle index within a frame (0 = idle, 1 = load cycle).
    int            m_k    = 0;
    logic [DW-1:0] m_tx   = '0;
    logic [DW-1:0] m_rx   = '0;
    logic [DW-1:0] m_dout = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_k    <= 0;
            m_dout <= '0;
        end else if (m_k == 0) begin
            if (send) m_k <= 1;
        end else if (m_k == 1) begin
            m_tx <= data_in;
            m_k  <= 2;
        end else if (m_k == LAST_K + 1) begin
            m_k <= 0;
        end else begin
            if ((m_k - 2) % BITC == HD - 1) m_rx <= {m_rx[DW-2:0], MISO};
            if (m_k == LAST_K) m_dout <= m_rx;
            m_k <= m_k + 1;
        end
    end

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] cur_pat = '0;
    logic [DW-1:0] mosi_cap = '0;
    int            n_pulse = 0;
    int            n_done = 0;
    logic          prev_sclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle: compare every pin on the falling edge, then drive MISO.
    task automatic step();
        int   j;
        logic in_x, e_ss, e_sclk, e_mosi, e_done;
        @(negedge clk);
        j      = m_k - 2;
        in_x   = (m_k >= 2) && (m_k <= LAST_K);
        e_ss   = (m_k == 0);
        e_sclk = in_x && (j % BITC >= HD);
        e_mosi = in_x ? m_tx[DW-1 - j / BITC] : 1'b0;
        e_done = (m_k == LAST_K + 1);
        check("SS", 32'(SS), 32'(e_ss));
        check("SCLK", 32'(SCLK), 32'(e_sclk));
        check("MOSI", 32'(MOSI), 32'(e_mosi));
        check("done", 32'(done), 32'(e_done));
        check("data_out", 32'(data_out), 32'(m_dout));
        if (SCLK && !prev_sclk) begin
            mosi_cap = {mosi_cap[DW-2:0], MOSI};
            n_pulse++;
        end
        prev_sclk = SCLK;
        if (done) n_done++;
        if (in_x && (j % BITC == 4)) MISO = cur_pat[DW-1 - j / BITC];
    endtask

    // Runs a frame from an idle negedge to the idle negedge after done.
    task automatic frame(input logic [DW-1:0] d, input logic [DW-1:0] pat, input int busy_k,
                         input bit lit, input logic [DW-1:0] lit_mosi, input logic [DW-1:0] lit_dout);
        int p0, d0;
        cur_pat = pat;
        data_in = d;
        p0 = n_pulse;
        d0 = n_done;
        send = 1'b1;
        step();
        send = 1'b0;
        for (int k = 2; k <= LAST_K + 2; k++) begin
            if (k == 6) data_in = DW'($urandom);
            send = (k == busy_k);
            step();
        end
        send = 1'b0;
        check("mosi_word", 32'(mosi_cap), 32'(d));
        check("sclk_pulses", 32'(n_pulse - p0), 32'(DW));
        check("done_pulses", 32'(n_done - d0), 32'(1));
        check("data_out_word", 32'(data_out), 32'(pat));
        if (lit) begin
            check("mosi_literal", 32'(mosi_cap), 32'(lit_mosi));
            check("dout_literal", 32'(data_out), 32'(lit_dout));
        end
    endtask

    initial begin
        logic [DW-1:0] rd, rp;
        int            d0;

        // Reset for two edges.
        @(negedge clk);
        step();
        check("rst_SS", 32'(SS), 32'(1));
        check("rst_SCLK", 32'(SCLK), 32'(0));
        check("rst_MOSI", 32'(MOSI), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_data_out", 32'(data_out), 32'(16'h0000));
        rst = 1'b0;
        step();

        frame(16'hAA33, 16'hAAAA, 0, 1'b1, 16'hAA33, 16'hAAAA);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        frame(16'h8888, 16'h0AA8, 0, 1'b1, 16'h8888, 16'h0AA8);

        // send while busy: mid-XFER, then during the done cycle.
        rd = DW'($urandom); rp = DW'($urandom);
        frame(rd, rp, 100, 1'b0, '0, '0);
        rd = DW'($urandom); rp = DW'($urandom);
        frame(rd, rp, LAST_K + 1, 1'b0, '0, '0);

        // Reset in the middle of bit 7.
        cur_pat = DW'($urandom);
        data_in = DW'($urandom);
        d0 = n_done;
        send = 1'b1;
        step();
        send = 1'b0;
        for (int k = 2; k <= 2 + 7 * BITC + 3; k++) step();
        rst = 1'b1;
        step();
        check("abort_SS", 32'(SS), 32'(1));
        check("abort_SCLK", 32'(SCLK), 32'(0));
        check("abort_MOSI", 32'(MOSI), 32'(0));
        check("abort_data_out", 32'(data_out), 32'(0));
        rst = 1'b0;
        repeat (20) step();
        check("abort_no_done", 32'(n_done - d0), 32'(0));
        rd = DW'($urandom); rp = DW'($urandom);
        frame(rd, rp, 0, 1'b0, '0, '0);

        // Back-to-back frames, then a few with random idle gaps.
        rd = DW'($urandom); rp = DW'($urandom);
        frame(rd, rp, 0, 1'b0, '0, '0);
        rd = DW'($urandom); rp = DW'($urandom);
        frame(rd, rp, 0, 1'b0, '0, '0);
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) step();
            rd = DW'($urandom); rp = DW'($urandom);
            frame(rd, rp, int'($urandom_range(0, LAST_K + 1)), 1'b0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
